// File: rtl/lsu.sv
// Load/store unit between the execute-stage ALU and the data-memory bus.
// Holds the core for the whole access; reports decode faults and bus timeouts.
module lsu #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          st_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;

    logic          illegal;
    logic          misaligned;
    logic          timed_out;
    logic [3:0]    be_next;
    logic [31:0]   wdata_next;
    logic [31:0]   shifted;
    logic [31:0]   load_val;

    always_comb begin
        illegal    = is_store ? (funct3[2] | (funct3 == 3'b011))
                              : ((funct3 == 3'b011) | (funct3[2:1] == 2'b11));
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                misaligned = addr[0];
                be_next    = 4'b0011 << addr[1:0];
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                misaligned = (addr[1:0] != 2'b00);
            end
        endcase
    end

    // Load data is taken from the lane chosen by the latched byte offset.
    always_comb begin
        shifted  = mem_rdata >> {off_q, 3'b000};
        load_val = shifted;
        case (f3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'b0, shifted[7:0]};
            3'b101:  load_val = {16'b0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    assign timed_out = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            st_q      <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        st_q  <= is_store;
                        f3_q  <= funct3;
                        off_q <= addr[1:0];
                        busy  <= 1'b1;
                        if (illegal || misaligned) begin
                            state <= DONE;
                            done  <= 1'b1;
                            fault <= 1'b1;
                            if (!is_store) begin
                                rdata <= '0;
                            end
                        end else begin
                            state     <= REQ;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be_next;
                            mem_wdata <= wdata_next;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (st_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (timed_out) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                        if (!st_q) begin
                            rdata <= '0;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_rvalid) begin
                        rdata <= load_val;
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (timed_out) begin
                        rdata <= '0;
                        state <= DONE;
                        done  <= 1'b1;
                        fault <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomised scoreboard bench for lsu: stimulus pushes expectations from a
// byte-level memory-access model; a negedge monitor pops and compares on done.
module tb_lsu;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .fault(fault), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          fault;
        logic [31:0] rdata;
        int          lat;
        int          reqs;
        logic [31:0] baddr;
        logic [3:0]  be;
        bit          we;
        logic [31:0] bwdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          tests = 0;
    int          failed = 0;
    logic [31:0] model_rdata = '0;
    int          busy_cnt, req_cnt;
    bit          bus_bad, proto_bad;
    logic [31:0] prev_rdata;
    bit          r_st;
    logic [2:0]  r_f3;
    int          r_g, r_r;
    logic [2:0]  load_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Memory-order view of a load: pick the addressed bytes, then extend.
    function automatic logic [31:0] loadModel(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
        int unsigned v = w >> (8 * off);
        case (f3)
            3'b000: begin v = v % 256;   if (v >= 128)   v += 32'hFFFF_FF00; end
            3'b001: begin v = v % 65536; if (v >= 32768) v += 32'hFFFF_0000; end
            3'b100: v = v % 256;
            3'b101: v = v % 65536;
            default: ;
        endcase
        return v;
    endfunction

    // One core-side access: the bus answers after g withheld cycles, load data r cycles after grant.
    task automatic applyStimulus(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 input int g, input int r);
        exp_t e;
        int   size, reqc, since, cyc;
        bit   ill, mis, granted;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ill  = st ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis  = (a % size) != 0;
        e.baddr  = a - (a % 4);
        e.be     = 4'(((1 << size) - 1) << (a % 4));
        e.we     = st;
        e.bwdata = '0;
        for (int i = 0; i < 4; i++) e.bwdata[8*i +: 8] = wd[8*(i % size) +: 8];
        if (ill || mis) begin
            e.fault = 1; e.lat = 1; e.reqs = 0;
        end else if (st) begin
            if (g + 1 <= T) begin e.fault = 0; e.lat = g + 2; e.reqs = g + 1; end
            else            begin e.fault = 1; e.lat = T + 1; e.reqs = T;     end
        end else if (g + 1 + r <= T) begin
            e.fault = 0; e.lat = g + r + 2; e.reqs = g + 1;
        end else begin
            e.fault = 1; e.lat = T + 1; e.reqs = (g + 1 <= T) ? g + 1 : T;
        end
        if (!st) model_rdata = e.fault ? 32'h0 : loadModel(f3, a[1:0], rd);
        e.rdata = model_rdata;
        exp_q.push_back(e);

        start = 1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        reqc = 0; since = 0; cyc = 0; granted = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
            if (done) begin
                start = 0;
                break;
            end
            if (cyc > 60) begin
                checkOutput("txn_completes", {31'b0, done}, 1);
                void'(exp_q.pop_front());
                start = 0;
                break;
            end
            if (mem_req) begin
                reqc++;
                mem_rvalid = 1'($urandom_range(0, 1));
                if (reqc == g + 1) begin
                    mem_gnt = 1; granted = 1; since = 0;
                end
            end else if (granted) begin
                since++;
                if (since == r) begin
                    mem_rvalid = 1; mem_rdata = rd;
                end
            end
        end
    endtask

    // Scoreboard monitor: accumulates per-transaction observations, compares on done.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0; req_cnt = 0; bus_bad = 0; proto_bad = 0; prev_rdata = rdata;
            end else begin
                if (busy) busy_cnt++;
                if (mem_req) begin
                    req_cnt++;
                    if (exp_q.size() > 0) begin
                        if (mem_addr !== exp_q[0].baddr || mem_be !== exp_q[0].be ||
                            mem_we !== exp_q[0].we ||
                            (exp_q[0].we && mem_wdata !== exp_q[0].bwdata))
                            bus_bad = 1;
                    end
                end
                if (!done && (fault || rdata !== prev_rdata)) proto_bad = 1;
                if (done) begin
                    checkOutput("pending_expectation", {31'b0, exp_q.size() > 0}, 1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        checkOutput("fault", {31'b0, fault}, {31'b0, cur.fault});
                        checkOutput("rdata", rdata, cur.rdata);
                        checkOutput("latency", busy_cnt, cur.lat);
                        checkOutput("req_cycles", req_cnt, cur.reqs);
                        checkOutput("bus_fields", {31'b0, bus_bad}, 0);
                        checkOutput("protocol", {31'b0, proto_bad}, 0);
                    end
                    busy_cnt = 0; req_cnt = 0; bus_bad = 0; proto_bad = 0;
                end
                prev_rdata = rdata;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1; start = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        #1 rst_n = 0;
        #2;
        checkOutput("reset_busy", {31'b0, busy}, 0);
        checkOutput("reset_done", {31'b0, done}, 0);
        checkOutput("reset_fault", {31'b0, fault}, 0);
        checkOutput("reset_mem_req", {31'b0, mem_req}, 0);
        checkOutput("reset_mem_we", {31'b0, mem_we}, 0);
        checkOutput("reset_rdata", rdata, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_mem_be", {28'b0, mem_be}, 0);
        checkOutput("reset_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        applyStimulus(0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1);
        applyStimulus(0, 3'b101, 32'h0000_1002, 32'h0, 32'h80FF_1234, 0, 1);
        applyStimulus(1, 3'b000, 32'h0000_2001, 32'h0000_00AB, $urandom, 0, 1);
        applyStimulus(1, 3'b001, 32'h0000_2002, 32'h1234_CDEF, $urandom, 0, 1);
        applyStimulus(0, 3'b010, 32'h0000_1002, $urandom, $urandom, 0, 1);
        applyStimulus(1, 3'b001, 32'h0000_3001, $urandom, $urandom, 0, 1);
        applyStimulus(0, 3'b010, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 3, 2);
        applyStimulus(0, 3'b011, 32'h0000_4004, 32'h0, $urandom, 0, 1);
        applyStimulus(1, 3'b100, 32'h0000_4008, $urandom, $urandom, 0, 1);

        applyStimulus(0, 3'b010, 32'h0000_5000, 32'h0, 32'h1111_2222, 40, 1);
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_rvalid = 0;
        checkOutput("late_rvalid_rdata", rdata, model_rdata);
        checkOutput("late_rvalid_busy", {31'b0, busy}, 0);

        // Abort a load in WAIT with reset.
        start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h0000_6000;
        @(posedge clk); #1;
        mem_gnt = 1;
        @(posedge clk); #1;
        mem_gnt = 0;
        #2 rst_n = 0; #1;
        checkOutput("rst_wait_busy", {31'b0, busy}, 0);
        checkOutput("rst_wait_req", {31'b0, mem_req}, 0);
        start = 0; model_rdata = 0;
        @(posedge clk); #1;
        checkOutput("rst_wait_no_done", {31'b0, done}, 0);
        rst_n = 1;
        @(posedge clk); #1;
        checkOutput("rst_wait_idle_done", {31'b0, done}, 0);

        // Abort a load in REQ: mem_req must fall without a clock edge.
        start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h0000_6100;
        @(posedge clk); #1;
        checkOutput("req_before_rst", {31'b0, mem_req}, 1);
        #2 rst_n = 0; #1;
        checkOutput("rst_req_req", {31'b0, mem_req}, 0);
        checkOutput("rst_req_busy", {31'b0, busy}, 0);
        start = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        checkOutput("rst_req_no_done", {31'b0, done}, 0);

        applyStimulus(0, 3'b010, 32'h0000_7000, 32'h0, 32'h1234_5678, 0, 1);

        for (int n = 0; n < 150; n++) begin
            r_st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) r_f3 = 3'($urandom);
            else if (r_st)                 r_f3 = 3'($urandom_range(0, 2));
            else                           r_f3 = load_codes[$urandom_range(0, 4)];
            r_g = ($urandom_range(0, 15) == 0) ? 9 : $urandom_range(0, 4);
            r_r = $urandom_range(1, 4);
            applyStimulus(r_st, r_f3, $urandom, $urandom, $urandom, r_g, r_r);
        end

        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
